// File: rtl/enc_rr_arbiter_8.sv
// rtl/enc_rr_arbiter_8.sv - 8-way round-robin arbiter with registered one-hot and encoded grant (optional ARB_TIMEOUT_EN)
module enc_rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state, state_d;
    logic [2:0] ptr, ptr_d;
    logic [7:0] gnt_d;
    logic [2:0] idx_d;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       win_found;
    logic       other_rel;
    logic       hold_hit;
    logic       rel;

    // Voluntary release causes: holder finished, holder withdrew, or arbiter disabled.
    assign other_rel = done | ~req[gnt_idx] | ~en;
    assign rel       = (state == BUSY) & (other_rel | hold_hit);
    assign gnt_vld   = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign hold_hit = (state == BUSY) && (hold_cnt == HOLD_LAST);
    assign timeout  = timeout_q;

    // Count consecutive BUSY cycles of the current grant; cleared on release and in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if ((state == BUSY) && !rel) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Flag the first IDLE cycle after a release caused only by the hold limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= hold_hit & ~other_rel;
        end
    end
`else
    logic [7:0] unused_max_hold;

    assign unused_max_hold = 8'(MAX_HOLD);
    assign hold_hit        = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Rotating priority search: first set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state, next-grant and pointer rotation.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    state_d = BUSY;
                    gnt_d   = 8'd1 << win_idx;
                    idx_d   = win_idx;
                end
            end
            BUSY: begin
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    ptr_d   = gnt_idx + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            ptr     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_enc_rr_arbiter_8.sv
// tb/tb_enc_rr_arbiter_8.sv - directed self-checking bench for enc_rr_arbiter_8
module tb_enc_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_checks;
    int n_fail;

    logic [12:0] obs;
    logic [12:0] exp_v;

    localparam logic [12:0] IDLE_V = 13'b0;

    enc_rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {gnt, gnt_idx, gnt_vld, timeout};

    // Expected {gnt, gnt_idx, gnt_vld, timeout} while requester idx holds the grant.
    function automatic logic [12:0] busy_v(input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        return {oh, idx, 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, IDLE_V);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        en  = 1'b1;
        req = 8'b0000_0101;
        tick();
        exp_v = busy_v(3'd0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL basic_first_grant: got %h expected %h", obs, exp_v);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL basic_idle_gap: got %h expected %h", obs, IDLE_V);
        end
        tick();
        exp_v = busy_v(3'd2);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL basic_second_grant: got %h expected %h", obs, exp_v);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        en  = 1'b1;
        req = 8'b1000_0000;
        tick();
        exp_v = busy_v(3'd7);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_grant7: got %h expected %h", obs, exp_v);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'b1000_0001;
        tick();
        exp_v = busy_v(3'd0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_grant0: got %h expected %h", obs, exp_v);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        exp_v = busy_v(3'd7);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_regrant7: got %h expected %h", obs, exp_v);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs !== IDLE_V) begin
                n_fail++;
                $display("FAIL en_low_idle[%0d]: got %h expected %h", i, obs, IDLE_V);
            end
        end
        en = 1'b1;
        tick();
        exp_v = busy_v(3'd0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL en_rise_grant: got %h expected %h", obs, exp_v);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL en_drop_release: got %h expected %h", obs, IDLE_V);
        end
        en = 1'b1;
        tick();
        exp_v = busy_v(3'd1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL en_ptr_advanced: got %h expected %h", obs, exp_v);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_req_drop();
        do_reset();
        en  = 1'b1;
        req = 8'b0000_1000;
        tick();
        exp_v = busy_v(3'd3);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_grant3: got %h expected %h", obs, exp_v);
        end
        req = 8'b0001_0000;
        tick();
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL drop_release: got %h expected %h", obs, IDLE_V);
        end
        req = 8'b0001_1000;
        tick();
        exp_v = busy_v(3'd4);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_next_grant4: got %h expected %h", obs, exp_v);
        end
        req = 8'b0001_1111;
        tick();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_other_bits_ignored: got %h expected %h", obs, exp_v);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL drop_done_release: got %h expected %h", obs, IDLE_V);
        end
        req = 8'h00;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL done_in_idle: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        en  = 1'b1;
        req = 8'b0000_1000;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = busy_v(3'd3);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL to_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        tick();
        exp_v = 13'b0000_0000_000_0_1;
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL to_pulse: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = busy_v(3'd3);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL to_regrant: got %h expected %h", obs, exp_v);
        end
`else
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_v = busy_v(3'd3);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold_forever[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
`endif
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        en  = 1'b1;
        req = 8'b0010_0000;
        tick();
        exp_v = busy_v(3'd5);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL arst_grant5: got %h expected %h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL arst_immediate_clear: got %h expected %h", obs, IDLE_V);
        end
        req = 8'b0010_0001;
        #1;
        rst_n = 1'b1;
        tick();
        exp_v = busy_v(3'd0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL arst_first_grant0: got %h expected %h", obs, exp_v);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 8'h00;
        done     = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_enable();
        test_req_drop();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
